// File: rtl/dcache_arbiter.sv
// dcache_arbiter
//   Two-port arbiter in front of a single-ported data cache. One requester at a
//   time is granted, its operation is latched, a single read or write enable is
//   issued to the cache, read data is captured, and a one-cycle done pulse is
//   returned to the requester. Every output is driven from a flop.
//
//   Read  : IDLE -> ISSUE (cache_r_en) -> CAPT (cache_r_data captured) -> DONE
//   Write : IDLE -> ISSUE (cache_w_en) -> DONE
//
//   Optional build macro DCACHE_ARB_RR_EN:
//     defined   - simultaneous requests alternate via a last-grant pointer
//     undefined - fixed priority, requester 0 wins every tie
//
// Ports
//   clk, reset            clock; asynchronous active-low reset
//   req0/req1             access request, held until the matching done
//   we0/we1               1 = write, 0 = read
//   addr0/addr1           word address
//   wdata0/wdata1         write data
//   gnt0/gnt1             requester owns the cache (ISSUE through DONE)
//   done0/done1           one-cycle completion pulse
//   rdata0/rdata1         last read result per requester
//   busy                  state is not IDLE
//   cache_r_en/cache_w_en cache read / write enables (ISSUE only)
//   cache_addr            cache address, holds last latched value
//   cache_w_data          cache write data, holds last latched value
//   cache_r_data          registered cache read data (one cycle after r_en)
module dcache_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic              cache_r_en,
  output logic              cache_w_en,
  output logic [ADDR_W-1:0] cache_addr,
  output logic [DATA_W-1:0] cache_w_data,
  input  logic [DATA_W-1:0] cache_r_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPT, DONE} state_t;

  state_t state, state_d;

  logic              gnt0_d, gnt1_d;
  logic              done0_d, done1_d;
  logic [DATA_W-1:0] rdata0_d, rdata1_d;
  logic              busy_d;
  logic              r_en_d, w_en_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;
  logic              lat_we, lat_we_d;
  logic              sel1;
  logic              sel_we;

`ifdef DCACHE_ARB_RR_EN
  // last_gnt = 1 means requester 1 won most recently; a tie goes to the other one
  logic last_gnt, last_gnt_d;

  always_comb sel1 = req1 && (!req0 || !last_gnt);
`else
  // Requester 1 only wins when requester 0 is not asking
  always_comb sel1 = req1 && !req0;
`endif

  assign sel_we = sel1 ? we1 : we0;

  // Next-state and next-output logic; the granted requester is identified by
  // the gnt flops themselves, so no separate owner register is needed
  always_comb begin
    state_d  = state;
    gnt0_d   = gnt0;
    gnt1_d   = gnt1;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    rdata0_d = rdata0;
    rdata1_d = rdata1;
    r_en_d   = 1'b0;
    w_en_d   = 1'b0;
    addr_d   = cache_addr;
    wdata_d  = cache_w_data;
    lat_we_d = lat_we;
`ifdef DCACHE_ARB_RR_EN
    last_gnt_d = last_gnt;
`endif
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          state_d  = ISSUE;
          gnt0_d   = !sel1;
          gnt1_d   = sel1;
          lat_we_d = sel_we;
          addr_d   = sel1 ? addr1 : addr0;
          wdata_d  = sel1 ? wdata1 : wdata0;
          // Enable flops are loaded on entry so they are high exactly in ISSUE
          r_en_d   = !sel_we;
          w_en_d   = sel_we;
`ifdef DCACHE_ARB_RR_EN
          last_gnt_d = sel1;
`endif
        end
      end
      ISSUE: begin
        if (lat_we) begin
          state_d = DONE;
          done0_d = gnt0;
          done1_d = gnt1;
        end else begin
          state_d = CAPT;
        end
      end
      CAPT: begin
        // Cache data is valid now, one cycle after the read enable
        state_d = DONE;
        done0_d = gnt0;
        done1_d = gnt1;
        if (gnt0) rdata0_d = cache_r_data;
        if (gnt1) rdata1_d = cache_r_data;
      end
      DONE: begin
        state_d = IDLE;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      gnt0         <= 1'b0;
      gnt1         <= 1'b0;
      done0        <= 1'b0;
      done1        <= 1'b0;
      rdata0       <= '0;
      rdata1       <= '0;
      busy         <= 1'b0;
      cache_r_en   <= 1'b0;
      cache_w_en   <= 1'b0;
      cache_addr   <= '0;
      cache_w_data <= '0;
      lat_we       <= 1'b0;
    end else begin
      state        <= state_d;
      gnt0         <= gnt0_d;
      gnt1         <= gnt1_d;
      done0        <= done0_d;
      done1        <= done1_d;
      rdata0       <= rdata0_d;
      rdata1       <= rdata1_d;
      busy         <= busy_d;
      cache_r_en   <= r_en_d;
      cache_w_en   <= w_en_d;
      cache_addr   <= addr_d;
      cache_w_data <= wdata_d;
      lat_we       <= lat_we_d;
    end
  end

`ifdef DCACHE_ARB_RR_EN
  // Pointer starts at 1 so the first tie after reset goes to requester 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) last_gnt <= 1'b1;
    else        last_gnt <= last_gnt_d;
  end
`endif

endmodule

// File: tb/tb_dcache_arbiter.sv
// tb_dcache_arbiter
//   Bench for dcache_arbiter with a behavioural cache (mem[i] = i at start,
//   registered read). Stimulus pushes the expected per-port read data and done
//   cycle into per-port queues; a monitor pops and compares on every done
//   pulse and checks the enable/grant exclusivity rules every cycle.
//   Honours DCACHE_ARB_RR_EN for the tie-break expectations.
module tb_dcache_arbiter;

  logic        clk;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [15:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, done0, done1, busy;
  logic [15:0] rdata0, rdata1;
  logic        cache_r_en, cache_w_en;
  logic [15:0] cache_addr, cache_w_data, cache_r_data;

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          pushes0 = 0, pushes1 = 0;
  int          dones0 = 0, dones1 = 0;
  logic [15:0] last_rd0 = 16'h0, last_rd1 = 16'h0;
  logic [15:0] mem [0:65535];
  logic [15:0] m1 [0:15];

  dcache_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .req0         (req0),
    .req1         (req1),
    .we0          (we0),
    .we1          (we1),
    .addr0        (addr0),
    .addr1        (addr1),
    .wdata0       (wdata0),
    .wdata1       (wdata1),
    .gnt0         (gnt0),
    .gnt1         (gnt1),
    .done0        (done0),
    .done1        (done1),
    .rdata0       (rdata0),
    .rdata1       (rdata1),
    .busy         (busy),
    .cache_r_en   (cache_r_en),
    .cache_w_en   (cache_w_en),
    .cache_addr   (cache_addr),
    .cache_w_data (cache_w_data),
    .cache_r_data (cache_r_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural data cache: registered read, write on enable
  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = i[15:0];
    cache_r_data = 16'h0;
  end

  always @(posedge clk) begin
    if (cache_w_en) mem[cache_addr] <= cache_w_data;
    if (cache_r_en) cache_r_data <= mem[cache_addr];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: pops expectations on done pulses and checks exclusivity rules
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        checkOutput("en_overlap", {31'b0, cache_r_en && cache_w_en}, 32'd0);
        checkOutput("gnt_overlap", {31'b0, gnt0 && gnt1}, 32'd0);
      end
      if (done0) begin
        dones0++;
        if (q0.size() == 0) begin
          checkOutput("unexpected_done0", 32'd1, 32'd0);
        end else begin
          e = q0.pop_front();
          checkOutput("rdata0", {16'b0, rdata0}, {16'b0, e.data});
          if (e.due >= 0) checkOutput("done0_cycle", cyc, e.due);
        end
      end
      if (done1) begin
        dones1++;
        if (q1.size() == 0) begin
          checkOutput("unexpected_done1", 32'd1, 32'd0);
        end else begin
          e = q1.pop_front();
          checkOutput("rdata1", {16'b0, rdata1}, {16'b0, e.data});
          if (e.due >= 0) checkOutput("done1_cycle", cyc, e.due);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    last_rd0 = 16'h0;
    last_rd1 = 16'h0;
  endtask

  // Single access from one port, started at a negedge with the DUT idle
  task automatic applyStimulus(input int port, input logic we, input logic [15:0] addr,
                               input logic [15:0] wdata, input logic [15:0] exp_rd);
    int   k;
    int   n;
    exp_t e;
    k = cyc;
    if (port == 0) begin
      req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata;
      if (!we) last_rd0 = exp_rd;
      e.data = last_rd0;
    end else begin
      req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata;
      if (!we) last_rd1 = exp_rd;
      e.data = last_rd1;
    end
    e.due = we ? k + 2 : k + 3;
    if (port == 0) begin q0.push_back(e); pushes0++; end
    else begin q1.push_back(e); pushes1++; end
    @(negedge clk);
    checkOutput("issue_gnt", {30'b0, gnt1, gnt0}, (port == 0) ? 32'd1 : 32'd2);
    checkOutput("issue_r_en", {31'b0, cache_r_en}, {31'b0, !we});
    checkOutput("issue_w_en", {31'b0, cache_w_en}, {31'b0, we});
    checkOutput("issue_addr", {16'b0, cache_addr}, {16'b0, addr});
    checkOutput("issue_busy", {31'b0, busy}, 32'd1);
    if (we) checkOutput("issue_wdata", {16'b0, cache_w_data}, {16'b0, wdata});
    @(negedge clk);
    checkOutput("post_issue_en", {30'b0, cache_r_en, cache_w_en}, 32'd0);
    checkOutput("post_issue_addr", {16'b0, cache_addr}, {16'b0, addr});
    n = 0;
    while (!((port == 0) ? done0 : done1) && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (n >= 10) checkOutput("done_timeout", 32'd0, 32'd1);
    if (port == 0) req0 = 1'b0; else req1 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int   k;
    int   n;
    int   end_cyc;
    exp_t e;
    reset = 1'b0;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = 16'h0; addr1 = 16'h0; wdata0 = 16'h0; wdata1 = 16'h0;
    for (int i = 0; i < 16; i++) m1[i] = 16'h0200 + 16'(i);
    repeat (3) @(negedge clk);

    $display("[TB] reset state");
    checkOutput("rst_gnt", {30'b0, gnt1, gnt0}, 32'd0);
    checkOutput("rst_done", {30'b0, done1, done0}, 32'd0);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_en", {30'b0, cache_r_en, cache_w_en}, 32'd0);
    checkOutput("rst_rdata", {rdata1, rdata0}, 32'd0);
    checkOutput("rst_cache", {cache_addr, cache_w_data}, 32'd0);
    reset = 1'b1;

    $display("[TB] directed single accesses");
    applyStimulus(0, 1'b0, 16'h0005, 16'h0000, 16'h0005);
    applyStimulus(1, 1'b1, 16'h0010, 16'hBEEF, 16'h0000);
    applyStimulus(0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF);
    checkOutput("rdata1_after_write", {16'b0, rdata1}, 32'd0);
    applyStimulus(1, 1'b0, 16'h0033, 16'h0000, 16'h0033);
    applyStimulus(1, 1'b1, 16'h0034, 16'h1234, 16'h0000);
    applyStimulus(0, 1'b0, 16'h0034, 16'h0000, 16'h1234);

    $display("[TB] both requesters held for four reads");
    do_reset();
    k = cyc;
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0030;
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0041;
    for (int i = 0; i < 4; i++) begin
      e.due = k + 3 + 4 * i;
`ifdef DCACHE_ARB_RR_EN
      if (i % 2 == 0) begin e.data = 16'h0030; q0.push_back(e); pushes0++; end
      else begin e.data = 16'h0041; q1.push_back(e); pushes1++; end
`else
      e.data = 16'h0030; q0.push_back(e); pushes0++;
`endif
    end
    n = 0;
    while (cyc != k + 15 && n < 40) begin
      @(negedge clk);
      n++;
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);

    $display("[TB] reset during read capture");
    do_reset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0020;
    repeat (2) @(negedge clk);
    checkOutput("capt_busy", {31'b0, busy}, 32'd1);
    checkOutput("capt_gnt0", {31'b0, gnt0}, 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("midrst_gnt", {30'b0, gnt1, gnt0}, 32'd0);
    checkOutput("midrst_done", {30'b0, done1, done0}, 32'd0);
    checkOutput("midrst_busy", {31'b0, busy}, 32'd0);
    checkOutput("midrst_en", {30'b0, cache_r_en, cache_w_en}, 32'd0);
    checkOutput("midrst_cache", {cache_addr, cache_w_data}, 32'd0);
    checkOutput("midrst_rdata", {rdata1, rdata0}, 32'd0);
    req0 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("post_rst_rdata0", {16'b0, rdata0}, 32'd0);
    checkOutput("post_rst_busy", {31'b0, busy}, 32'd0);

    $display("[TB] random traffic");
    end_cyc = cyc + 10000;
    fork
      begin
        int          m;
        logic [15:0] a;
        exp_t        r;
        while (cyc < end_cyc) begin
          @(negedge clk);
          if ($urandom_range(0, 3) == 0) begin
            a = 16'h0100 + 16'($urandom_range(0, 255));
            r.data = a; r.due = -1;
            q0.push_back(r); pushes0++;
            req0 = 1'b1; we0 = 1'b0; addr0 = a; wdata0 = 16'($urandom);
            m = 0;
            do begin @(negedge clk); m++; end while (!done0 && m < 200);
            if (!done0) checkOutput("rand_done0_timeout", 32'd0, 32'd1);
            req0 = 1'b0;
          end
        end
      end
      begin
        int          m;
        int          idx;
        logic        w;
        logic [15:0] d;
        exp_t        r;
        while (cyc < end_cyc) begin
          @(negedge clk);
          if ($urandom_range(0, 2) == 0) begin
            idx = $urandom_range(0, 15);
            w = 1'($urandom_range(0, 1));
            d = 16'($urandom);
            if (w) m1[idx] = d;
            else last_rd1 = m1[idx];
            r.data = last_rd1; r.due = -1;
            q1.push_back(r); pushes1++;
            req1 = 1'b1; we1 = w; addr1 = 16'h0200 + 16'(idx); wdata1 = d;
            m = 0;
            do begin @(negedge clk); m++; end while (!done1 && m < 200);
            if (!done1) checkOutput("rand_done1_timeout", 32'd0, 32'd1);
            req1 = 1'b0;
          end
        end
      end
    join

    repeat (6) @(negedge clk);
    checkOutput("q0_empty", q0.size(), 32'd0);
    checkOutput("q1_empty", q1.size(), 32'd0);
    checkOutput("done0_count", dones0, pushes0);
    checkOutput("done1_count", dones1, pushes1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_arbiter.md
DCACHE_ARBITER -- requirements
Module: dcache_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, cache address width.
REQ-002 SHALL have parameter DATA_W, default 16, cache data width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports req0/req1  input  1  requester n access request, held until done_n.
REQ-006 SHALL have ports we0/we1  input  1  requester n op select: 1=write, 0=read, stable while req_n.
REQ-007 SHALL have ports addr0/addr1  input  ADDR_W  requester n word address, stable while req_n.
REQ-008 SHALL have ports wdata0/wdata1  input  DATA_W  requester n write data, stable while req_n.
REQ-009 SHALL have ports gnt0/gnt1  output  1  requester n owns the cache, from ISSUE through DONE.
REQ-010 SHALL have ports done0/done1  output  1  one-cycle completion pulse to requester n.
REQ-011 SHALL have ports rdata0/rdata1  output  DATA_W  last read result for requester n, held until its next read completes.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-013 SHALL have ports cache_r_en/cache_w_en  output  1  dcache read/write enables.
REQ-014 SHALL have ports cache_addr/cache_w_data  output  ADDR_W/DATA_W  dcache address and write data.
REQ-015 SHALL have port cache_r_data  input  DATA_W  dcache registered read data (valid one cycle after cache_r_en).

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, CAPT, DONE; all outputs registered.
REQ-017 IDLE: if any req_n high, SHALL select a winner, latch its we/addr/wdata, set gnt_n, go ISSUE; else stay IDLE.
REQ-018 ISSUE: SHALL assert exactly one of cache_r_en (read) or cache_w_en (write) for exactly one cycle with latched addr/wdata on cache_addr/cache_w_data; next state CAPT for read, DONE for write.
REQ-019 CAPT: SHALL load cache_r_data into rdata_n of the granted requester; next state DONE.
REQ-020 DONE: SHALL assert done_n for one cycle, then clear gnt_n and return to IDLE.
REQ-021 Latency from req_n sampled in IDLE to done_n SHALL be 3 cycles for reads, 2 for writes; a new grant SHALL be possible in the cycle after DONE.
REQ-022 req_n still high in IDLE after its done_n SHALL be treated as a new request.
REQ-023 cache_r_en and cache_w_en SHALL never be high simultaneously and SHALL be low outside ISSUE.
REQ-024 cache_addr/cache_w_data SHALL hold their last latched value outside ISSUE.
REQ-025 Request changes on the losing or granted port during ISSUE/CAPT/DONE SHALL not affect the current access.
REQ-026 rdata_n of the non-granted requester and after writes SHALL be unchanged.
REQ-027 A single requester SHALL be granted regardless of arbitration policy.

Reset
REQ-028 reset low SHALL immediately force IDLE, gnt0/gnt1=0, done0/done1=0, rdata0/rdata1=0, busy=0, cache_r_en=cache_w_en=0, cache_addr=0, cache_w_data=0, last-grant pointer=1.
REQ-029 Reset mid-access SHALL abandon the access without any done_n pulse; an ISSUE write cut by reset is not guaranteed to land.
REQ-030 After reset release, first edge SHALL evaluate requests from IDLE.

Configuration
REQ-031 Macro DCACHE_ARB_RR_EN defined: on simultaneous req0 and req1 in IDLE, SHALL grant the requester not granted last, then update the pointer to the winner.
REQ-032 DCACHE_ARB_RR_EN undefined: SHALL use fixed priority, requester 0 always wins ties; pointer logic absent.

Verification
REQ-033 After reset, req0=1, we0=0, addr0=0x0005 -> cache_r_en high 1 cycle at cycle 1, done0 at cycle 3, rdata0=0x0005 (dcache reset content mem[i]=i).
REQ-034 req1=1, we1=1, addr1=0x0010, wdata1=0xBEEF -> cache_w_en 1 cycle, done1 2 cycles later; then read 0x0010 via req0 -> rdata0=0xBEEF, rdata1 unchanged.
REQ-035 req0 and req1 both held high for 4 reads (DCACHE_ARB_RR_EN) -> grants 0,1,0,1; without macro -> grants 0,0,0,0 while req0 remains high.
REQ-036 reset asserted during CAPT of a read to 0x0020 -> all outputs zero same cycle, no done pulse, rdata unchanged from 0.
REQ-037 Random req/we traffic on both ports for 10000 cycles -> cache_r_en and cache_w_en never overlap, gnt0 and gnt1 never overlap, every req receives exactly one done.
